// File: rtl/foobar_pkg.sv
// foobar_pkg: shared types and constants for the foobar event logging path.
//   evt_rec_t  - one captured event: type {bar,foo}, both count snapshots, timestamp.
//   EVT_*      - record type encodings.
// The ts field is sized for the widest supported timestamp (TS_W <= EVT_TS_MAX_W).
// Users cast it down to their own TS_W.
package foobar_pkg;

    localparam logic [1:0] EVT_FOO  = 2'b01;
    localparam logic [1:0] EVT_BAR  = 2'b10;
    localparam logic [1:0] EVT_BOTH = 2'b11;

    localparam int unsigned EVT_TS_MAX_W = 32;
    // Bits of a record excluding the timestamp: type + two 8-bit counts.
    localparam int unsigned EVT_HDR_W    = 18;

    typedef struct packed {
        logic [1:0]              evt_type;
        logic [7:0]              cnt_foo;
        logic [7:0]              cnt_bar;
        logic [EVT_TS_MAX_W-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/foobar_sync_fifo.sv
// foobar_sync_fifo: generic first-word-fall-through FIFO.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous flush, dominates push/pop
//   push, wdata - write request and data (caller must not push when full without a pop)
//   pop         - read request (caller must not pop when empty)
//   rdata       - head entry, zero while empty
//   level       - occupancy, 0..DEPTH
//   full, empty - occupancy flags
module foobar_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/foobar_evt_fifo.sv
// foobar_evt_fifo: captures foobar foo/bar events into records and buffers them
// in a FWFT FIFO for a downstream valid/ready consumer.
//   clk, rst_n          - clock, asynchronous active-low reset
//   clr                 - synchronous flush of FIFO, overflow state and timestamp
//   en, foo, bar        - capture enable and event pulses
//   count_foo/count_bar - running counts snapshotted into each record
//   out_valid/out_ready - head-record handshake
//   out_type/out_cnt_*  - head record fields (zero while empty)
//   out_ts              - head record timestamp
//   level, full         - occupancy
//   ovf, ovf_cnt        - sticky drop flag and saturating drop count
// Build option: define FOOBAR_EVT_TS_EN to add a free-running timestamp counter
// (advances on every cycle with en=1) captured into each record. Without it,
// no timestamp is stored and out_ts is 0.
module foobar_evt_fifo
    import foobar_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned OVF_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   foo,
    input  logic                   bar,
    input  logic [7:0]             count_foo,
    input  logic [7:0]             count_bar,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_type,
    output logic [7:0]             out_cnt_foo,
    output logic [7:0]             out_cnt_bar,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   ovf,
    output logic [OVF_W-1:0]       ovf_cnt
);

`ifdef FOOBAR_EVT_TS_EN
    localparam int unsigned FW = EVT_HDR_W + TS_W;
`else
    localparam int unsigned FW = EVT_HDR_W;
`endif

    logic           evt, push, pop, drop;
    logic           fifo_full, fifo_empty;
    logic [FW-1:0]  wdata, rdata;
    evt_rec_t       wr_rec, rd_rec;
    logic           ovf_q;
    logic [OVF_W-1:0] ovf_cnt_q;

    assign evt  = en & (foo | bar);
    // clr wins: no pop, no store, no drop accounting in a flush cycle.
    assign pop  = ~fifo_empty & out_ready & ~clr;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push = evt & (~fifo_full | pop) & ~clr;
    assign drop = evt & fifo_full & ~pop & ~clr;

`ifdef FOOBAR_EVT_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clr) begin
            ts_q <= '0;
        end else if (en) begin
            ts_q <= ts_q + 1'b1;
        end
    end

    always_comb begin
        wr_rec          = '0;
        wr_rec.evt_type = {bar, foo};
        wr_rec.cnt_foo  = count_foo;
        wr_rec.cnt_bar  = count_bar;
        wr_rec.ts       = EVT_TS_MAX_W'(ts_q);
        wdata = {wr_rec.evt_type, wr_rec.cnt_foo, wr_rec.cnt_bar, TS_W'(wr_rec.ts)};
        rd_rec = {rdata[FW-1:TS_W], EVT_TS_MAX_W'(rdata[TS_W-1:0])};
    end
`else
    always_comb begin
        wr_rec          = '0;
        wr_rec.evt_type = {bar, foo};
        wr_rec.cnt_foo  = count_foo;
        wr_rec.cnt_bar  = count_bar;
        // Timestamp occupies the struct LSBs; shifting it out leaves the header.
        wdata  = FW'(wr_rec >> EVT_TS_MAX_W);
        rd_rec = {rdata, {EVT_TS_MAX_W{1'b0}}};
    end
`endif

    foobar_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (clr) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign out_valid   = ~fifo_empty;
    assign out_type    = rd_rec.evt_type;
    assign out_cnt_foo = rd_rec.cnt_foo;
    assign out_cnt_bar = rd_rec.cnt_bar;
    assign out_ts      = TS_W'(rd_rec.ts);
    assign full        = fifo_full;
    assign ovf         = ovf_q;
    assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_foobar_evt_fifo.sv
module tb_foobar_evt_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 4;
    localparam int unsigned OVF_W = 2;
`ifdef FOOBAR_EVT_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0, en = 1'b0, foo = 1'b0, bar = 1'b0, out_ready = 1'b0;
    logic [7:0]       count_foo = '0, count_bar = '0;
    logic             out_valid, full, ovf;
    logic [1:0]       out_type;
    logic [7:0]       out_cnt_foo, out_cnt_bar;
    logic [TS_W-1:0]  out_ts;
    logic [3:0]       level;
    logic [OVF_W-1:0] ovf_cnt;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    foobar_evt_fifo #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .OVF_W (OVF_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .en          (en),
        .foo         (foo),
        .bar         (bar),
        .count_foo   (count_foo),
        .count_bar   (count_bar),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_type    (out_type),
        .out_cnt_foo (out_cnt_foo),
        .out_cnt_bar (out_cnt_bar),
        .out_ts      (out_ts),
        .level       (level),
        .full        (full),
        .ovf         (ovf),
        .ovf_cnt     (ovf_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of records plus drop/timestamp bookkeeping.
    typedef struct {
        logic [1:0]      t;
        logic [7:0]      cf;
        logic [7:0]      cb;
        logic [TS_W-1:0] ts;
    } rec_t;

    rec_t             q[$];
    logic             m_ovf;
    logic [OVF_W-1:0] m_cnt;
    logic [TS_W-1:0]  m_ts;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
            m_ts  = '0;
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
            m_ts  = '0;
        end else begin
            rec_t r;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (en && (foo || bar)) begin
                if (q.size() < DEPTH) begin
                    r.t  = {bar, foo};
                    r.cf = count_foo;
                    r.cb = count_bar;
                    r.ts = TS_ON ? m_ts : '0;
                    q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt != {OVF_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
            end
            if (en) m_ts = m_ts + 1'b1;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            rec_t h;
            h = '{t: 2'b00, cf: 8'd0, cb: 8'd0, ts: '0};
            if (q.size() != 0) h = q[0];
            chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_level", 32'(level), 32'(q.size()));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
            chk("m_ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
            chk("m_type", 32'(out_type), 32'(h.t));
            chk("m_cnt_foo", 32'(out_cnt_foo), 32'(h.cf));
            chk("m_cnt_bar", 32'(out_cnt_bar), 32'(h.cb));
            chk("m_ts", 32'(out_ts), 32'(h.ts));
        end
    end

    task automatic cyc(input logic e, input logic f, input logic b, input logic [7:0] cf,
                       input logic [7:0] cb, input logic rdy, input logic c);
        en = e; foo = f; bar = b; count_foo = cf; count_bar = cb; out_ready = rdy; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_type", 32'(out_type), 32'd0);

        // Timestamps: events at cycles 3 and 20, 4-bit counter wraps.
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
        idle(16);
        cyc(1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0);
        chk("ts_level", 32'(level), 32'd2);
        chk("ts_first", 32'(out_ts), TS_ON ? 32'd3 : 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("ts_second", 32'(out_ts), TS_ON ? 32'd4 : 32'd0);
        chk("ts_second_cf", 32'(out_cnt_foo), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("ts_drained", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

        // Single foo event, one-cycle latency.
        cyc(1'b1, 1'b1, 1'b0, 8'd5, 8'd0, 1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_type", 32'(out_type), 32'd1);
        chk("t1_cf", 32'(out_cnt_foo), 32'd5);
        chk("t1_level", 32'(level), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

        // Fill to full, then one drop.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(10 + i), 8'(20 + i), 1'b0, 1'b0);
            if (i == 7) begin
                chk("t2_full", 32'(full), 32'd1);
                chk("t2_level8", 32'(level), 32'd8);
            end
        end
        chk("t2_ovf", 32'(ovf), 32'd1);
        chk("t2_ovf_cnt", 32'(ovf_cnt), 32'd1);

        // Full + pop + event: accepted, level stays at DEPTH.
        cyc(1'b1, 1'b1, 1'b0, 8'd99, 8'd77, 1'b1, 1'b0);
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_order_cf", 32'(out_cnt_foo), (i < 7) ? 32'(11 + i) : 32'd99);
            chk("t3_order_cb", 32'(out_cnt_bar), (i < 7) ? 32'(21 + i) : 32'd77);
            cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        end
        chk("t3_empty", 32'(out_valid), 32'd0);

        // Simultaneous foo and bar: one record of type both.
        cyc(1'b1, 1'b1, 1'b1, 8'd3, 8'd7, 1'b0, 1'b0);
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_type", 32'(out_type), 32'd3);
        chk("t4_cf", 32'(out_cnt_foo), 32'd3);
        chk("t4_cb", 32'(out_cnt_bar), 32'd7);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

        // level=4 with ovf set, then clr with a concurrent event and pop.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 8'd0, 8'(40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("t5_level4", 32'(level), 32'd4);
        chk("t5_ovf_pre", 32'(ovf), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1, 1'b1);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_ovf_cnt", 32'(ovf_cnt), 32'd0);

        // Drop counter saturation (OVF_W=2 -> max 3).
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i), 8'd0, 1'b0, 1'b0);
        chk("sat_ovf_cnt", 32'(ovf_cnt), 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

        // en low: no capture, but buffered records drain; ready while empty is harmless.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'd9, 8'd9, 1'b1, 1'b0);
        chk("en_low_level", 32'(level), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'd50, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'd0, 8'd51, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("hold_cf", 32'(out_cnt_foo), 32'd50);
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("en_low_next", 32'(out_cnt_bar), 32'd51);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("en_low_drained", 32'(level), 32'd0);

        // Asynchronous reset with data buffered.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'(60 + i), 8'd0, 1'b0, 1'b0);
        chk("ar_level_pre", 32'(level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_cf", 32'(out_cnt_foo), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 8'd70, 8'd0, 1'b0, 1'b0);
        chk("ar_after", 32'(out_cnt_foo), 32'd70);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
